twiddle_pair_gen: RTL and testbench
===================================

# twiddle_pair_gen

Streaming twiddle-factor generator for the NTT datapath: on a start pulse it produces successive powers of a root of unity ω, two per beat as (ω^(2k), ω^(2k+1)) mod Q. The pair feeds the two weight inputs of the butterfly multiply-modulo stage. The block sits on the producer side of that weight interface. Powers are computed incrementally with a registered modular multiplier, so no twiddle ROM is required. Output uses a valid/ready handshake so the butterfly pipeline can stall it.

## Interface
- WIDTH, 18, data width of ω, Q and all weights.
- Q, 12289, modulus (prime, < 2^WIDTH).
- CNT_W, 9, width of the pair-count input.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- omega  in  WIDTH  root of unity (forward or inverse), captured on start.
- count  in  CNT_W  number of pairs to emit, captured on start.
- busy  out  1  high in SETUP and RUN.
- w_valid  out  1  pair available.
- w_ready  in  1  consumer accepts the pair.
- weight_1  out  WIDTH  ω^(2k) mod Q.
- weight_2  out  WIDTH  ω^(2k+1) mod Q.
- done  out  1  one-cycle pulse after the final pair is accepted.
- last  out  1  only with TWIDDLE_LAST_EN; high with the final pair.

## Operation
- Registers:
  - w_r: captured ω, stored as omega mod Q.
  - s_r: step, ω² mod Q.
  - a_r and b_r: the current pair.
  - rem_r: pairs remaining.
- FSM states: IDLE, SETUP, RUN.
- IDLE:
  - If start is high and count ≠ 0: capture w_r and rem_r = count, then go to SETUP.
  - If start is high and count = 0: pulse done next cycle and stay in IDLE.
  - start is ignored in every other state.
- SETUP (one cycle):
  - s_r ← w_r·w_r mod Q; a_r ← 1; b_r ← w_r.
  - Next state is RUN.
- RUN:
  - w_valid = 1; weight_1 = a_r; weight_2 = b_r.
  - On handshake (w_valid & w_ready):
    - a_r ← a_r·s_r mod Q; b_r ← b_r·s_r mod Q; rem_r ← rem_r − 1.
    - If rem_r = 1, go to IDLE and assert done next cycle.
  - Without a handshake, a_r, b_r and rem_r hold unchanged.
- Arithmetic:
  - Each multiply is a full 2·WIDTH-bit product, reduced to [0, Q−1] within the same cycle.
  - Outputs are always < Q. The power sequence wraps naturally modulo Q.
- Reset: any state returns to IDLE. All outputs go to 0: w_valid, done, busy, last, weight_1, weight_2. Any in-flight sequence is abandoned.

## Timing
- start sampled at edge t → SETUP during t+1 → first w_valid at t+2.
- Throughput is 1 pair per cycle while w_ready is held high.
- Latency from a handshake to the next pair is 1 cycle.
- done asserts the cycle after the final handshake, with busy already 0. A new start is accepted in that same cycle.
- w_ready is a don't-care when w_valid is low.
- weight_1 and weight_2 are registered; they are stable whenever w_valid is high and not yet accepted.

## Configuration
- TWIDDLE_LAST_EN defined:
  - Adds the last output, which equals w_valid & (rem_r = 1).
  - last is 0 after reset and 0 outside RUN.
- TWIDDLE_LAST_EN not defined: the last port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic sequence: reset, then start with ω=3, count=4, w_ready=1.
  - Pairs (1,3), (9,27), (81,243), (729,2187) on consecutive cycles; first pair at t+2.
  - done pulses once.
- Wrap-around: ω=3, count=5.
  - Fifth pair is (6561, 7394), with 19683 mod 12289 = 7394.
- Backpressure: ω=3, count=4, w_ready toggles 1,0,0,1,…
  - Pairs hold steady during stalls; the sequence matches the basic case; exactly 4 handshakes occur.
- Edge inputs:
  - count=0 → no w_valid, done pulse the next cycle.
  - ω=12290 → behaves as ω=1, giving all pairs (1,1).
  - start while busy → ignored; the sequence is unaffected.
- Reset mid-run: rst_n low during the 2nd pair.
  - All outputs go to 0 immediately. After release, a new start with ω=5, count=2 gives (1,5), (25,125).
- Macro on: with TWIDDLE_LAST_EN defined, last is high only alongside (729,2187) in the count=4 run. This holds under the backpressure pattern too.

Source files
------------

// File: rtl/twiddle_pair_gen.sv
// Streaming twiddle-pair generator: emits (w^2k, w^2k+1) mod Q per beat over valid/ready.
// Optional `last` output is enabled by defining TWIDDLE_LAST_EN.
module twiddle_pair_gen #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned Q     = 12289,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] omega_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             busy_o,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic [WIDTH-1:0] weight_1_o,
  output logic [WIDTH-1:0] weight_2_o,
`ifdef TWIDDLE_LAST_EN
  output logic             last_o,
`endif
  output logic             done_o
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] QW = PW'(Q);

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d, s_q, s_d, a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             handshake;

  // Full-width product reduced into [0, Q-1] in the same cycle.
  function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [PW-1:0] p;
    logic [PW-1:0] r;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
    r = p % QW;
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] modq(input logic [WIDTH-1:0] x);
    logic [PW-1:0] r;
    r = {{WIDTH{1'b0}}, x} % QW;
    return r[WIDTH-1:0];
  endfunction

  assign handshake = (state_q == RUN) && w_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && (count_i != '0)) state_d = SETUP;
      SETUP:   state_d = RUN;
      RUN:     if (handshake && (rem_q == CNT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: SETUP seeds the pair with (1, w) and squares w to get the per-beat step.
  always_comb begin
    w_d    = w_q;
    s_d    = s_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (count_i != '0) begin
            w_d   = modq(omega_i);
            rem_d = count_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETUP: begin
        s_d = mulmod(w_q, w_q);
        a_d = WIDTH'(1);
        b_d = w_q;
      end
      RUN: begin
        if (handshake) begin
          a_d   = mulmod(a_q, s_q);
          b_d   = mulmod(b_q, s_q);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q    <= '0;
      s_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      w_q    <= w_d;
      s_q    <= s_d;
      a_q    <= a_d;
      b_q    <= b_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    w_valid_o  = (state_q == RUN);
    busy_o     = (state_q != IDLE);
    done_o     = done_q;
    weight_1_o = a_q;
    weight_2_o = b_q;
`ifdef TWIDDLE_LAST_EN
    last_o     = (state_q == RUN) && (rem_q == CNT_W'(1));
`endif
  end

endmodule

// File: tb/tb_twiddle_pair_gen.sv
// Self-checking bench for twiddle_pair_gen; expected pairs come from direct modular powers of omega.
// Define TWIDDLE_LAST_EN to also check the last output.
module tb_twiddle_pair_gen;

  localparam int WIDTH = 18;
  localparam int Q     = 12289;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] omega = '0;
  logic [CNT_W-1:0] count = '0;
  logic             busy, w_valid, done;
  logic             w_ready = 1'b0;
  logic [WIDTH-1:0] weight_1, weight_2;
`ifdef TWIDDLE_LAST_EN
  logic             last;
`endif

  int checks = 0;
  int errors = 0;

  twiddle_pair_gen #(.WIDTH(WIDTH), .Q(Q), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .omega_i    (omega),
    .count_i    (count),
    .busy_o     (busy),
    .w_valid_o  (w_valid),
    .w_ready_i  (w_ready),
    .weight_1_o (weight_1),
    .weight_2_o (weight_2),
`ifdef TWIDDLE_LAST_EN
    .last_o     (last),
`endif
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // omega^e mod Q by plain repeated multiplication.
  function automatic longint pw(input longint base, input int e);
    longint r;
    longint b;
    r = 1;
    b = base % Q;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, w_valid, done, weight_1, weight_2} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b valid=%b done=%b w1=%0d w2=%0d want all 0",
               busy, w_valid, done, weight_1, weight_2);
    end
`ifdef TWIDDLE_LAST_EN
    checks++;
    if (last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_last got %b want 0", last);
    end
`endif
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: random ready; 3: ready high plus a stray start mid-run
  task automatic run_seq(input logic [WIDTH-1:0] om, input int cnt, input int mode, input string name);
    int  k;
    int  cyc;
    logic rdy;
    @(posedge clk); #1;
    start = 1'b1; omega = om; count = CNT_W'(cnt); w_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; omega = $urandom;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || w_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_setup got busy=%b valid=%b want busy=1 valid=0", name, busy, w_valid);
    end
    k = 0;
    cyc = 0;
    while (k < cnt && cyc < 4000) begin
      @(posedge clk); #1;
      case (mode)
        1:       rdy = ((cyc % 3) == 0);
        2:       rdy = 1'($urandom % 2);
        default: rdy = 1'b1;
      endcase
      w_ready = rdy;
      if (mode == 3) begin
        start = (cyc == 1);
        omega = 18'd7;
        count = 9'd9;
      end
      @(negedge clk);
      checks++;
      if (w_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s_valid pair %0d got valid=%b busy=%b want 1,1", name, k, w_valid, busy);
      end
      checks++;
      if (weight_1 !== WIDTH'(pw(om, 2 * k)) || weight_2 !== WIDTH'(pw(om, 2 * k + 1))) begin
        errors++;
        $display("[TB] FAIL %s_pair %0d got (%0d,%0d) want (%0d,%0d)", name, k, weight_1, weight_2,
                 pw(om, 2 * k), pw(om, 2 * k + 1));
      end
`ifdef TWIDDLE_LAST_EN
      checks++;
      if (last !== (k == cnt - 1)) begin
        errors++;
        $display("[TB] FAIL %s_last pair %0d got %b want %b", name, k, last, (k == cnt - 1));
      end
`endif
      if (rdy) k++;
      cyc++;
    end
    if (k < cnt) begin
      errors++;
      $display("[TB] FAIL %s_timeout got %0d handshakes want %0d", name, k, cnt);
    end
    @(posedge clk); #1;
    w_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done got done=%b busy=%b valid=%b want 1,0,0", name, done, busy, w_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_done_once got done=%b valid=%b want 0,0", name, done, w_valid);
    end
  endtask

  task automatic test_basic();         run_seq(18'd3, 4, 0, "basic");     endtask
  task automatic test_wrap();          run_seq(18'd3, 5, 0, "wrap");      endtask
  task automatic test_backpressure();  run_seq(18'd3, 4, 1, "backpress"); endtask
  task automatic test_omega_wrap();    run_seq(18'd12290, 4, 0, "omega_q1"); endtask
  task automatic test_back_to_back();  run_seq(18'd3, 6, 3, "start_busy"); endtask

  task automatic test_count_zero();
    @(posedge clk); #1;
    start = 1'b1; omega = 18'd3; count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL count0_done got done=%b busy=%b valid=%b want 1,0,0", done, busy, w_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL count0_after got done=%b busy=%b valid=%b want 0,0,0", done, busy, w_valid);
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1;
    start = 1'b1; omega = 18'd3; count = 9'd4; w_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (w_valid !== 1'b1 || weight_1 !== 18'd9 || weight_2 !== 18'd27) begin
      errors++;
      $display("[TB] FAIL midrun_pair2 got valid=%b (%0d,%0d) want 1 (9,27)", w_valid, weight_1, weight_2);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, w_valid, done, weight_1, weight_2} !== '0) begin
      errors++;
      $display("[TB] FAIL midrun_reset got busy=%b valid=%b done=%b w1=%0d w2=%0d want all 0",
               busy, w_valid, done, weight_1, weight_2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; w_ready = 1'b0;
    run_seq(18'd5, 2, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_seq(WIDTH'($urandom), 1 + int'($urandom_range(0, 19)), 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_omega_wrap();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
